// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared types and constants for the multdiv_seq multiply/divide
// sequencer and its datapath.
//   state_t  : FSM encoding IDLE -> RUN -> FIX -> DONE
//   op_t     : latched operation (OP_MULT / OP_DIV)
//   ITER_CNT : number of RUN iterations, CNT_W: iteration counter width
//   INT_MIN  : most negative 32-bit value, used for the INT_MIN / -1 check
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_t;

  localparam int          ITER_CNT = 32;
  localparam int          CNT_W    = 5;
  localparam logic [31:0] INT_MIN  = 32'h8000_0000;

endpackage

// File: rtl/multdiv_datapath.sv
// multdiv_datapath: shared add/sub + shift datapath for multdiv_seq.
// Holds the 65-bit working register and one WIDTH+1 adder used by both
// algorithms.
//   MULT (radix-2 Booth): work = {acc[64:33], multiplier[32:1], q_minus1[0]}
//   DIV  (restoring)    : work = {remainder[64:32], quotient[31:0]}
// Ports:
//   clock, reset_n   : clock and synchronous active-low reset
//   load, load_op    : latch operands for a new operation of type load_op
//   op               : operation currently in progress
//   step             : perform one iteration
//   fix              : one-cycle quotient sign correction
//   operand_a/_b     : multiplicand/dividend, multiplier/divisor
//   prod_lo/prod_hi  : low/high halves of the Booth product
//   quotient         : signed quotient after the fix cycle
module multdiv_datapath
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  op_t              load_op,
  input  op_t              op,
  input  logic             step,
  input  logic             fix,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] prod_lo,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] quotient
);

  localparam int WW = 2 * WIDTH + 1;

  logic [WW-1:0]    work_reg, work_next;
  logic [WIDTH-1:0] mcand_reg;  // multiplicand (MULT) or |divisor| (DIV)
  logic             neg_reg;    // quotient must be negated in FIX
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   add_a, add_b, add_sum;
  logic             add_sub;

  // Magnitudes; |INT_MIN| stays 0x8000_0000, which is correct as unsigned.
  assign mag_a = operand_a[WIDTH-1] ? (~operand_a + WIDTH'(1)) : operand_a;
  assign mag_b = operand_b[WIDTH-1] ? (~operand_b + WIDTH'(1)) : operand_b;

  // Shared adder. The Booth accumulator is sign-extended to WIDTH+1 bits so
  // acc +/- INT_MIN cannot wrap before the arithmetic shift.
  always_comb begin
    add_a   = {work_reg[WW-1], work_reg[WW-1:WIDTH+1]};
    add_b   = {mcand_reg[WIDTH-1], mcand_reg};
    add_sub = (work_reg[1:0] == 2'b10);
    if (fix) begin
      // 0 - quotient
      add_a   = '0;
      add_b   = {1'b0, work_reg[WIDTH-1:0]};
      add_sub = 1'b1;
    end else if (op == OP_DIV) begin
      // Trial subtract of the divisor from the left-shifted remainder.
      add_a   = work_reg[2*WIDTH-1:WIDTH-1];
      add_b   = {1'b0, mcand_reg};
      add_sub = 1'b1;
    end
    add_sum = add_sub ? (add_a - add_b) : (add_a + add_b);
  end

  always_comb begin
    work_next = work_reg;
    if (load) begin
      if (load_op == OP_MULT) begin
        work_next = {{WIDTH{1'b0}}, operand_b, 1'b0};
      end else begin
        work_next = {{(WIDTH+1){1'b0}}, mag_a};
      end
    end else if (step) begin
      if (op == OP_MULT) begin
        // Booth pair 01 adds, 10 subtracts; the 33-bit sum supplies the
        // sign fill for the right shift.
        if (work_reg[1] != work_reg[0]) begin
          work_next = {add_sum, work_reg[WIDTH:1]};
        end else begin
          work_next = {work_reg[WW-1], work_reg[WW-1:1]};
        end
      end else begin
        // Negative difference means restore (keep the shifted remainder).
        if (!add_sum[WIDTH]) begin
          work_next = {add_sum, work_reg[WIDTH-2:0], 1'b1};
        end else begin
          work_next = {add_a, work_reg[WIDTH-2:0], 1'b0};
        end
      end
    end else if (fix) begin
      if (op == OP_DIV && neg_reg) begin
        work_next[WIDTH-1:0] = add_sum[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      work_reg  <= '0;
      mcand_reg <= '0;
      neg_reg   <= 1'b0;
    end else begin
      work_reg <= work_next;
      if (load) begin
        mcand_reg <= (load_op == OP_MULT) ? operand_a : mag_b;
        neg_reg   <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
      end
    end
  end

  assign prod_lo  = work_reg[WIDTH:1];
  assign prod_hi  = work_reg[WW-1:WIDTH+1];
  assign quotient = work_reg[WIDTH-1:0];

endmodule

// File: rtl/multdiv_seq.sv
// multdiv_seq: multi-cycle signed multiply/divide sequencer.
// A start pulse latches operands; RUN iterates 32 cycles, FIX applies the
// quotient sign, DONE registers the result and strobes data_resultRDY.
// A new start while busy aborts and restarts; MULT wins if both pulse.
// Ports:
//   clock, reset_n          : clock, synchronous active-low reset
//   data_operandA/B         : operands, sampled only on the start edge
//   ctrl_MULT, ctrl_DIV     : one-cycle start pulses
//   data_result             : low product word or quotient (held until next DONE)
//   data_exception          : mult overflow, div by zero, or INT_MIN / -1
//   data_resultRDY          : one-cycle completion strobe
//   busy                    : start edge through the RDY cycle inclusive
// Build option: MULTDIV_DIVZERO_FAST_EN makes a divide by zero jump straight
// to DONE from the start edge.
module multdiv_seq
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  op_t              op_reg, start_op;
  logic             start, b_zero;
  logic             div_zero_reg, div_ovf_reg;
  logic [WIDTH-1:0] result_reg;
  logic             exc_reg, rdy_reg;
  logic             step, fix, done;
  logic             mult_ovf;
  logic [WIDTH-1:0] prod_lo, prod_hi, quotient;

  assign start    = ctrl_MULT | ctrl_DIV;
  assign start_op = ctrl_MULT ? OP_MULT : OP_DIV;
  assign b_zero   = (data_operandB == '0);
  assign mult_ovf = (prod_hi != {WIDTH{prod_lo[WIDTH-1]}});

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Next-state logic; a start from any state restarts the sequence.
  always_comb begin
    state_next = state_reg;
    if (start) begin
`ifdef MULTDIV_DIVZERO_FAST_EN
      state_next = (start_op == OP_DIV && b_zero) ? DONE : RUN;
`else
      state_next = RUN;
`endif
    end else begin
      case (state_reg)
        IDLE:    state_next = IDLE;
        RUN:     if (cnt_reg == CNT_W'(ITER_CNT - 1)) state_next = FIX;
        FIX:     state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Output / strobe logic; a start on the same edge suppresses the old op.
  always_comb begin
    step = (state_reg == RUN)  && !start;
    fix  = (state_reg == FIX)  && !start;
    done = (state_reg == DONE) && !start;
    busy = (state_reg != IDLE) || rdy_reg;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_reg      <= '0;
      op_reg       <= OP_MULT;
      div_zero_reg <= 1'b0;
      div_ovf_reg  <= 1'b0;
      result_reg   <= '0;
      exc_reg      <= 1'b0;
      rdy_reg      <= 1'b0;
    end else begin
      rdy_reg <= 1'b0;
      if (start) begin
        cnt_reg      <= '0;
        op_reg       <= start_op;
        div_zero_reg <= b_zero;
        div_ovf_reg  <= (data_operandA == INT_MIN) && (data_operandB == '1);
      end else if (step) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
      if (done) begin
        rdy_reg <= 1'b1;
        if (op_reg == OP_MULT) begin
          result_reg <= prod_lo;
          exc_reg    <= mult_ovf;
        end else begin
          // Restoring division by zero yields all ones; force the defined 0.
          result_reg <= div_zero_reg ? '0 : quotient;
          exc_reg    <= div_zero_reg | div_ovf_reg;
        end
      end
    end
  end

  multdiv_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (start),
    .load_op   (start_op),
    .op        (op_reg),
    .step      (step),
    .fix       (fix),
    .operand_a (data_operandA),
    .operand_b (data_operandB),
    .prod_lo   (prod_lo),
    .prod_hi   (prod_hi),
    .quotient  (quotient)
  );

  assign data_result    = result_reg;
  assign data_exception = exc_reg;
  assign data_resultRDY = rdy_reg;

endmodule

// File: tb/tb_multdiv_seq.sv
// Scoreboard bench for multdiv_seq: each start pushes the expected result,
// exception and latency; the RDY monitor pops and compares.
module tb_multdiv_seq;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] data_operandA, data_operandB;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY, busy;

`ifdef MULTDIV_DIVZERO_FAST_EN
  localparam int DZ_LAT = 1;
`else
  localparam int DZ_LAT = 34;
`endif

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          start_edge;
    int          lat;
  } sb_t;

  sb_t         sb_q[$];
  sb_t         mon_e;
  int          checks = 0;
  int          errors = 0;
  int          edge_cnt = 0;
  logic [31:0] last_res = 32'd0;
  logic [31:0] rnd_a, rnd_b;
  logic [32:0] rnd_m;
  logic        rnd_mult;
  int          rnd_lat;

  multdiv_seq #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) edge_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: {exception, result}
  function automatic logic [32:0] model(input logic is_mult, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    logic [31:0]        r;
    if (is_mult) begin
      p = $signed(a) * $signed(b);
      return {(p != {{32{p[31]}}, p[31:0]}), p[31:0]};
    end
    if (b == 32'd0) return {1'b1, 32'd0};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
    r = $signed(a) / $signed(b);
    return {1'b0, r};
  endfunction

  // RDY monitor: every strobe must match the oldest outstanding op.
  always @(negedge clock) begin
    if (data_resultRDY) begin
      if (sb_q.size() == 0) begin
        check("rdy_unexpected", 64'd1, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        $display("txn result=%08h exc=%0d latency=%0d", data_result, data_exception,
                 edge_cnt - mon_e.start_edge);
        check("result", {32'd0, data_result}, {32'd0, mon_e.res});
        check("exception", {63'd0, data_exception}, {63'd0, mon_e.exc});
        check("latency", 64'(edge_cnt - mon_e.start_edge), 64'(mon_e.lat));
      end
    end
  end

  // Called #1 after a posedge; the next posedge is the start edge.
  task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic ee, input int lat);
    sb_t e;
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    e.res         = er;
    e.exc         = ee;
    e.start_edge  = edge_cnt + 1;
    e.lat         = lat;
    sb_q.push_back(e);
    @(posedge clock); #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_done(input int lat);
    int busy_cnt = 0;
    for (int i = 0; i < lat + 6; i++) begin
      @(negedge clock);
      if (busy) busy_cnt++;
      if (lat > 2 && i == lat / 2)
        check("hold_result", {32'd0, data_result}, {32'd0, last_res});
    end
    check("busy_len", 64'(busy_cnt), 64'(lat + 1));
    check("sb_drain", 64'(sb_q.size()), 64'd0);
    @(posedge clock); #1;
  endtask

  task automatic run_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic ee, input int lat);
    start_op(m, d, a, b, er, ee, lat);
    wait_done(lat);
    last_res = er;
  endtask

  initial begin
    reset_n       = 1'b0;
    ctrl_MULT     = 1'b1;  // reset must win over a start
    ctrl_DIV      = 1'b0;
    data_operandA = 32'd3;
    data_operandB = 32'd3;
    repeat (2) @(posedge clock);
    #1 ctrl_MULT = 1'b0;
    @(negedge clock);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_rdy", {63'd0, data_resultRDY}, 64'd0);
    check("rst_result", {32'd0, data_result}, 64'd0);
    check("rst_exc", {63'd0, data_exception}, 64'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    run_op(1, 0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 34);
    run_op(1, 0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 34);
    run_op(1, 0, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0, 34);
    run_op(1, 0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 34);
    run_op(0, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 34);
    run_op(0, 1, 32'd100, 32'd7, 32'h0000_000E, 1'b0, 34);
    run_op(0, 1, 32'd5, 32'd0, 32'h0000_0000, 1'b1, DZ_LAT);
    run_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 34);

    // Restart: the aborted MULT must never produce an RDY.
    start_op(1, 0, 32'd3, 32'd4, 32'd12, 1'b0, 34);
    repeat (9) @(posedge clock); #1;
    sb_q.delete(sb_q.size() - 1);
    start_op(0, 1, 32'd100, 32'd7, 32'h0000_000E, 1'b0, 34);
    wait_done(34);
    last_res = 32'h0000_000E;

    run_op(1, 1, 32'd6, 32'd3, 32'h0000_0012, 1'b0, 34);

    // Reset at counter 15 aborts silently and clears outputs.
    start_op(1, 0, 32'd5, 32'd6, 32'd30, 1'b0, 34);
    repeat (15) @(posedge clock); #1;
    reset_n = 1'b0;
    sb_q.delete();
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_rdy", {63'd0, data_resultRDY}, 64'd0);
    check("abort_result", {32'd0, data_result}, 64'd0);
    check("abort_exc", {63'd0, data_exception}, 64'd0);
    last_res = 32'd0;
    repeat (40) @(negedge clock);
    @(posedge clock); #1;
    run_op(1, 0, 32'd2, 32'd2, 32'd4, 1'b0, 34);

    for (int i = 0; i < 8; i++) begin
      rnd_mult = i[0];
      rnd_a    = $urandom;
      rnd_b    = $urandom >> $urandom_range(0, 30);
      if (i == 6) rnd_a = -rnd_a;
      rnd_m    = model(rnd_mult, rnd_a, rnd_b);
      rnd_lat  = (!rnd_mult && rnd_b == 32'd0) ? DZ_LAT : 34;
      run_op(rnd_mult, !rnd_mult, rnd_a, rnd_b, rnd_m[31:0], rnd_m[32], rnd_lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
